// File: rtl/fft16_output_serializer_pkg.sv
// Shared constants and helpers for the 16-point FFT output serializer.
//   DW       : sample width of each real/imaginary part
//   FFT_N    : points per frame
//   IDX_W    : width of a frame index
//   FRAME_W  : width of one flattened parallel frame (FFT_N slots of DW bits)
//   digit_rev4(k) : radix-4 digit reversal of a 4-bit index, {k[1:0],k[3:2]}
package fft16_output_serializer_pkg;
  localparam int DW      = 16;
  localparam int FFT_N   = 16;
  localparam int IDX_W   = 4;
  localparam int FRAME_W = FFT_N * DW;

  function automatic logic [IDX_W-1:0] digit_rev4(input logic [IDX_W-1:0] k);
    return {k[1:0], k[3:2]};
  endfunction
endpackage

// File: rtl/fft16_output_serializer_if.sv
// Handshake bundle between the butterfly stage, the serializer and the
// downstream sample consumer.
//   in_valid/in_ready/in_re/in_im       : parallel frame capture (slot i at [DW*i +: DW])
//   out_valid/out_ready/out_re/out_im   : one complex sample per beat
//   out_index/out_last                  : natural-order bin and end-of-frame flag
//   frame_count                         : completed output frames
// slave  : serializer view; master : environment view.
interface fft16_output_serializer_if
  #(parameter int DW = fft16_output_serializer_pkg::DW);
  import fft16_output_serializer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [FFT_N*DW-1:0]   in_re;
  logic [FFT_N*DW-1:0]   in_im;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_re;
  logic [DW-1:0]         out_im;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic [15:0]           frame_count;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last, frame_count
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last, frame_count
  );
endinterface

// File: rtl/fft16_frame_bank.sv
// One 16-entry complex register bank: whole-frame parallel write, single
// indexed combinational read. Contents clear on reset.
//   clk, rst       : clock, async active-high reset
//   we             : write all 16 slots from wr_re/wr_im
//   wr_re, wr_im   : flattened frame, slot i at [DW*i +: DW]
//   rd_idx         : slot to read
//   rd_re, rd_im   : selected slot
module fft16_frame_bank
  import fft16_output_serializer_pkg::*;
#(
  parameter int DW = fft16_output_serializer_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [FFT_N*DW-1:0] wr_re,
  input  logic [FFT_N*DW-1:0] wr_im,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DW-1:0]       rd_re,
  output logic [DW-1:0]       rd_im
);
  logic [FFT_N-1:0][DW-1:0] re_q;
  logic [FFT_N-1:0][DW-1:0] im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (we) begin
      re_q <= wr_re;
      im_q <= wr_im;
    end
  end

  assign rd_re = re_q[rd_idx];
  assign rd_im = im_q[rd_idx];
endmodule

// File: rtl/fft16_output_serializer.sv
// Captures parallel 16-point FFT frames into a ping-pong pair of banks and
// streams each frame out in natural order, one registered sample per beat.
//   clk, rst : clock, async active-high reset
//   s        : serializer side of fft16_output_serializer_if
// DIGIT_REVERSE=1 reads slot {k[1:0],k[3:2]} for output bin k; 0 reads slot k.
module fft16_output_serializer
  import fft16_output_serializer_pkg::*;
#(
  parameter int DW            = fft16_output_serializer_pkg::DW,
  parameter bit DIGIT_REVERSE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  fft16_output_serializer_if.slave    s
);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]       state;
  logic [1:0]       full;
  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] rd_cnt;
  logic [15:0]      frame_cnt;
  logic [DW-1:0]    out_re_q, out_im_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;

  logic             cap, acc, last_acc, load;
  logic             nxt_bank;
  logic [IDX_W-1:0] nxt_cnt, rd_slot;
  logic [1:0][DW-1:0] bank_re, bank_im;

  // in_ready looks only at registered state, so a bank freed on this edge
  // becomes writable on the next one.
  assign s.in_ready = !full[wr_bank];
  assign cap        = s.in_valid && !full[wr_bank];
  assign acc        = (state == ST_STREAM) && s.out_ready;
  assign last_acc   = acc && (rd_cnt == 4'd15);

  // Address of the sample to present after this edge. Both banks see the same
  // slot index; nxt_bank picks which result lands in the output register.
  always_comb begin
    nxt_bank = rd_bank;
    nxt_cnt  = '0;
    load     = 1'b0;
    if (state == ST_IDLE) begin
      load = full[rd_bank];
    end else if (acc) begin
      if (rd_cnt == 4'd15) begin
        nxt_bank = ~rd_bank;
        load     = full[~rd_bank];
      end else begin
        nxt_cnt = rd_cnt + 4'd1;
        load    = 1'b1;
      end
    end
  end

  assign rd_slot = DIGIT_REVERSE ? digit_rev4(nxt_cnt) : nxt_cnt;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft16_frame_bank #(.DW(DW)) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (cap && (wr_bank == 1'(b))),
      .wr_re  (s.in_re),
      .wr_im  (s.in_im),
      .rd_idx (rd_slot),
      .rd_re  (bank_re[b]),
      .rd_im  (bank_im[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      frame_cnt  <= '0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      // Capture and release always target different banks: a full write bank
      // blocks capture, and only a full bank can be released.
      if (last_acc) full[rd_bank] <= 1'b0;
      if (cap) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (acc) rd_cnt <= nxt_cnt;
      if (last_acc) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (load) begin
        state      <= ST_STREAM;
        out_re_q   <= bank_re[nxt_bank];
        out_im_q   <= bank_im[nxt_bank];
        out_idx_q  <= nxt_cnt;
        out_last_q <= (nxt_cnt == 4'd15);
      end else if (last_acc) begin
        state <= ST_IDLE;
      end
    end
  end

  assign s.out_valid   = (state == ST_STREAM);
  assign s.out_re      = out_re_q;
  assign s.out_im      = out_im_q;
  assign s.out_index   = out_idx_q;
  assign s.out_last    = out_last_q;
  assign s.frame_count = frame_cnt;
endmodule

// File: tb/tb_fft16_output_serializer.sv
module tb_fft16_output_serializer;
  import fft16_output_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft16_output_serializer_if ifc ();
  fft16_output_serializer dut (.clk(clk), .rst(rst), .s(ifc));

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int mon_k  = 0;
  int exp_q[$];
  // natural-order bin k holds captured slot rev_tbl[k]
  int rev_tbl[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int bp_pat[4]   = '{1, 0, 0, 1};

  logic          prev_stall = 1'b0;
  logic [DW-1:0] h_re, h_im;
  logic [3:0]    h_idx;
  logic          h_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    logic [DW-1:0] e_re, e_im;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", ifc.out_valid, 1);
        chk("hold_re", ifc.out_re, h_re);
        chk("hold_im", ifc.out_im, h_im);
        chk("hold_idx", ifc.out_index, h_idx);
        chk("hold_last", ifc.out_last, h_last);
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", exp_q.size(), 1);
        end else begin
          e_re = DW'(exp_q[0] + rev_tbl[mon_k]);
          e_im = DW'(-(exp_q[0] + rev_tbl[mon_k]));
          chk($sformatf("idx k%0d", mon_k), ifc.out_index, mon_k);
          chk($sformatf("re k%0d", mon_k), ifc.out_re, e_re);
          chk($sformatf("im k%0d", mon_k), ifc.out_im, e_im);
          chk($sformatf("last k%0d", mon_k), ifc.out_last, (mon_k == 15));
          if (mon_k == 15) begin
            mon_k = 0;
            void'(exp_q.pop_front());
          end else begin
            mon_k++;
          end
        end
        beats++;
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      h_re   = ifc.out_re;
      h_im   = ifc.out_im;
      h_idx  = ifc.out_index;
      h_last = ifc.out_last;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int base);
    for (int i = 0; i < FFT_N; i++) begin
      ifc.in_re[DW*i +: DW] = DW'(base + i);
      ifc.in_im[DW*i +: DW] = DW'(-(base + i));
    end
    ifc.in_valid = 1'b1;
  endtask

  // Holds the frame until in_ready, returns after the capture edge.
  task automatic send_frame(input int base, output int waits);
    set_frame(base);
    waits = 0;
    while (!ifc.in_ready && waits < 200) begin
      cyc(1);
      waits++;
    end
    if (!ifc.in_ready) begin
      chk("capture_timeout", ifc.in_ready, 1);
    end else begin
      exp_q.push_back(base);
      cyc(1);
    end
  endtask

  initial begin
    int w, b0, c;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w, b0, c;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.in_re     = '0;
    ifc.in_im     = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // reset state
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_frame_count", ifc.frame_count, 0);
    chk("rst_out_re", ifc.out_re, 0);
    chk("rst_out_last", ifc.out_last, 0);

    // single frame, slot i = (i, -i)
    ifc.out_ready = 1'b1;
    b0 = beats;
    send_frame(0, w);
    ifc.in_valid = 1'b0;
    chk("lat_pre_valid", ifc.out_valid, 0);
    cyc(1);
    chk("lat_valid", ifc.out_valid, 1);
    chk("lat_idx0", ifc.out_index, 0);
    cyc(16);
    chk("single_beats", beats - b0, 16);
    chk("single_fc", ifc.frame_count, 1);
    chk("single_done_valid", ifc.out_valid, 0);

    // backpressure 1,0,0,1
    b0 = beats;
    send_frame(16, w);
    ifc.in_valid = 1'b0;
    c = 0;
    while (beats - b0 < 16 && c < 200) begin
      ifc.out_ready = (bp_pat[c % 4] != 0);
      cyc(1);
      c++;
    end
    chk("bp_beats", beats - b0, 16);
    chk("bp_fc", ifc.frame_count, 2);
    ifc.out_ready = 1'b1;
    cyc(1);
    chk("bp_done_valid", ifc.out_valid, 0);

    // ping-pong: three frames offered back-to-back
    b0 = beats;
    send_frame(32, w);
    chk("pp_wait1", w, 0);
    send_frame(48, w);
    chk("pp_wait2", w, 0);
    send_frame(64, w);
    chk("pp_wait3", w, 16);
    ifc.in_valid = 1'b0;
    cyc(31);
    chk("pp_beats_gapless", beats - b0, 48);
    chk("pp_fc", ifc.frame_count, 5);
    chk("pp_done_valid", ifc.out_valid, 0);

    // both banks full while stalled
    ifc.out_ready = 1'b0;
    send_frame(80, w);
    send_frame(96, w);
    set_frame(112);
    cyc(4);
    chk("full_in_ready", ifc.in_ready, 0);
    chk("full_out_valid", ifc.out_valid, 1);
    chk("full_idx", ifc.out_index, 0);
    chk("full_fc", ifc.frame_count, 5);
    b0 = beats;
    ifc.out_ready = 1'b1;
    send_frame(112, w);
    chk("full_wait3", w, 16);
    ifc.in_valid = 1'b0;
    cyc(31);
    chk("full_beats", beats - b0, 48);
    chk("full_fc_end", ifc.frame_count, 8);

    // reset mid-stream: frame 1 at beat 7, frame 2 buffered
    send_frame(128, w);
    send_frame(144, w);
    ifc.in_valid = 1'b0;
    cyc(7);
    chk("mid_idx7", ifc.out_index, 7);
    rst = 1'b1;
    #1;
    chk("mid_async_valid", ifc.out_valid, 0);
    chk("mid_async_idx", ifc.out_index, 0);
    exp_q.delete();
    mon_k = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_in_ready", ifc.in_ready, 1);
    chk("post_rst_fc", ifc.frame_count, 0);
    chk("post_rst_valid", ifc.out_valid, 0);
    b0 = beats;
    send_frame(160, w);
    ifc.in_valid = 1'b0;
    chk("post_lat_pre", ifc.out_valid, 0);
    cyc(1);
    chk("post_idx0", ifc.out_index, 0);
    cyc(16);
    chk("post_beats", beats - b0, 16);
    chk("post_fc", ifc.frame_count, 1);
    chk("post_exp_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft16_output_serializer.md
Name: fft16_output_serializer

Overview:
- Consumer end of the 16-point radix-4 FFT second butterfly stage.
- Captures one complete 16-point result frame presented in parallel by the butterfly stage.
- Reorders the frame from digit-reversed to natural order.
- Streams the frame out one complex sample per beat over a valid/ready interface.
- Ping-pong buffering lets the next frame be captured while the current one drains.

Parameters:
- DW, 16, sample width (two's complement) for each real and imaginary part.
- DIGIT_REVERSE, 1. When 1, output index k reads captured slot {k[1:0],k[3:2]}. When 0, it reads slot k directly.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the butterfly stage presents a complete frame.
- in_ready  out  1  a bank is free to accept a frame.
- in_re  in  16*DW  parallel real parts; slot i is in_re[DW*i+DW-1 : DW*i], i=0..15.
- in_im  in  16*DW  parallel imaginary parts; same slot layout as in_re.
- out_valid  out  1  out_re/out_im/out_index/out_last hold a valid sample.
- out_ready  in  1  downstream accepts the sample.
- out_re  out  DW  real part of the current output sample.
- out_im  out  DW  imaginary part of the current output sample.
- out_index  out  4  natural-order frequency bin k of the current sample.
- out_last  out  1  high when out_index==15.
- frame_count  out  16  count of completed output frames; wraps at 65535->0.

Behaviour:
- Storage: two banks (0,1), each 16 complex registers, plus full[1:0], wr_bank, rd_bank and a 4-bit rd_cnt.
- Reset (async, rst=1):
  - full=0, wr_bank=0, rd_bank=0, rd_cnt=0, frame_count=0.
  - out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0.
  - in_ready=1 (combinational !full[wr_bank]). Bank contents are cleared to 0.
- Capture: on a clock edge with in_valid && in_ready:
  - all 32 inputs are written into bank wr_bank;
  - full[wr_bank] is set and wr_bank toggles.
  - If in_valid && !in_ready, the frame is ignored; the upstream stage must hold it.
- Read FSM, two states:
  - IDLE: out_valid=0. When full[rd_bank]=1, go to STREAM. out_valid rises exactly 1 cycle after the capture edge of a frame into an empty pipeline.
  - STREAM: out_valid=1 and out_index=rd_cnt. out_re/out_im come from bank rd_bank at slot map(rd_cnt), and out_last=(rd_cnt==15).
  - On out_valid && out_ready with rd_cnt<15: rd_cnt increments.
  - On out_valid && out_ready with rd_cnt==15: rd_cnt returns to 0, full[rd_bank] clears, rd_bank toggles and frame_count increments. The FSM then stays in STREAM if the other bank is full (back-to-back, no bubble), otherwise returns to IDLE.
- Output hold: while out_valid && !out_ready, every out_* signal is held stable.
- Output registering: all out_* signals are registered. out_re/out_im are updated on the edge of each accepted beat, not driven combinationally from the bank mux.
- Simultaneous events:
  - Capture into bank A and read of bank B in the same cycle are independent.
  - Releasing the last beat of a bank while in_valid is high: in_ready uses the registered full value, so with both banks full the capture waits one cycle.
- Throughput: sustained 1 sample per cycle with out_ready=1. One frame is accepted per 16 cycles with no frame loss.
- Reset mid-stream: the partial frame and any buffered frame are discarded. out_valid drops asynchronously.
- No arithmetic is performed; samples pass through bit-exact.

Decomposition:
- Shared package holds:
  - DW and FFT_N=16;
  - the index-map function digit_rev4(k), returning {k[1:0],k[3:2]};
  - the slot extraction width constants.
- One natural sub-module: fft16_frame_bank (16-entry complex register bank with parallel write and 4-bit indexed read). It is instantiated twice.

Test Plan:
- Reset release with in_valid=0 -> in_ready=1, out_valid=0, frame_count=0.
- Single frame:
  - stimulus: slot i re=i, im=-i, DIGIT_REVERSE=1, out_ready=1;
  - required response: out_valid rises 1 cycle after capture; indices k=0..15 appear on consecutive cycles with out_re=digit_rev4(k) (sequence 0,4,8,12,1,5,...,15) and out_im the negative of that value; out_last only at k=15; frame_count=1.
- Backpressure: out_ready toggling 1,0,0,1 pattern -> no sample duplicated or skipped; outputs stable during stalls; 16 accepted beats.
- Ping-pong:
  - stimulus: three frames offered back-to-back (in_valid=1 continuously) with out_ready=1;
  - required response: first two captures immediate, third waits for in_ready; 48 beats with no gap between frames; frame_count=3.
- Both banks full with out_ready=0 -> in_ready=0; the third frame is held upstream and captured one cycle after the first bank's last beat is accepted.
- Reset mid-stream:
  - stimulus: rst asserted at beat 7 of frame 1 with frame 2 buffered;
  - required response: out_valid=0 immediately; after release in_ready=1, frame_count=0, and a new frame streams correctly from k=0.
